// File: rtl/weight_bank_streamer_pkg.sv
// Shared types for the weight bank streamer: fetch FSM states, the read tag
// that travels with every outstanding read, and output FIFO sizing.
package wbs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } wbs_state_t;

    localparam int ADDR_W_DEF = 10;

    typedef struct packed {
        logic [ADDR_W_DEF:0] offset;
        logic                last;
    } rd_tag_t;

    // The FIFO must absorb every read in the RAM pipe plus one beat held on Q.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/weight_bank_streamer_if.sv
// Command, output-stream and weight-write signals of the weight bank streamer.
interface weight_bank_streamer_if #(
    parameter int N_CH   = 20,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int CH_W   = $clog2(N_CH)
);

    logic                         Start;
    logic [ADDR_W-1:0]            Base_Addr;
    logic [ADDR_W:0]              Length;
    logic                         Busy;
    logic                         Done;

    logic [N_CH-1:0][DATA_W-1:0]  Q;
    logic [ADDR_W:0]              Q_Index;
    logic                         Q_Valid;
    logic                         Q_Ready;
    logic                         Q_Last;

    logic                         Wr_En;
    logic [CH_W-1:0]              Wr_Ch;
    logic [ADDR_W-1:0]            Wr_Addr;
    logic [DATA_W-1:0]            Wr_Data;
    logic                         Wr_Err;

    modport master (
        output Start, Base_Addr, Length, Q_Ready,
        output Wr_En, Wr_Ch, Wr_Addr, Wr_Data,
        input  Busy, Done, Q, Q_Index, Q_Valid, Q_Last, Wr_Err
    );

    modport slave (
        input  Start, Base_Addr, Length, Q_Ready,
        input  Wr_En, Wr_Ch, Wr_Addr, Wr_Data,
        output Busy, Done, Q, Q_Index, Q_Valid, Q_Last, Wr_Err
    );

endinterface

// File: rtl/weight_bank_streamer_bank_ram.sv
// Single-port synchronous RAM for one weight channel with a 1- or 2-cycle
// registered read; contents are loaded at runtime through the write port.
module bank_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];
    logic [DATA_W-1:0] q_p1;
    logic [DATA_W-1:0] q_p2;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        // p1: array read; p2: optional output register
        q_p1 <= mem[addr];
        q_p2 <= q_p1;
    end

    assign rdata = (RD_LAT == 2) ? q_p2 : q_p1;

endmodule

// File: rtl/weight_bank_streamer.sv
// N-channel weight bank with a lock-step sequential fetch engine, a
// credit-limited read pipe, an output FIFO with valid/ready, and a reload port.
module weight_bank_streamer
    import wbs_pkg::*;
#(
    parameter int N_CH   = 20,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    weight_bank_streamer_if.slave bus
);

    localparam int DEPTH = fifo_depth(RD_LAT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wbs_state_t                  state, state_nx;
    logic [ADDR_W-1:0]           base_r;
    logic [ADDR_W:0]             len_r;
    logic [ADDR_W:0]             iss_off;
    logic                        iss_last;
    logic                        start_ok;
    logic                        credit;
    logic                        issue;
    logic                        wr_ok;
    logic                        done_r;
    logic                        wr_err_r;
    logic [ADDR_W-1:0]           ram_addr;
    logic [N_CH-1:0][DATA_W-1:0] ram_q;

    rd_tag_t                     tag_p0, tag_p1, tag_p2;
    logic                        vld_p1, vld_p2;
    logic [1:0]                  in_flight;

    logic [N_CH-1:0][DATA_W-1:0] fifo_data [DEPTH];
    rd_tag_t                     fifo_tag  [DEPTH];
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [CNT_W-1:0]            fifo_cnt;
    logic                        push, pop, q_vld;
    rd_tag_t                     push_tag, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start_ok  = bus.Start && (state == IDLE) && (bus.Length != '0);
    assign wr_ok     = bus.Wr_En && (state == IDLE) && !bus.Start && (int'(bus.Wr_Ch) < N_CH);
    assign iss_last  = (iss_off == len_r - 1'b1);
    assign in_flight = {1'b0, vld_p1} + ((RD_LAT == 2) ? {1'b0, vld_p2} : 2'd0);
    assign credit    = (int'(in_flight) + int'(fifo_cnt)) < DEPTH;

    assign q_vld     = (fifo_cnt != '0);
    assign head      = fifo_tag[rd_ptr];
    assign pop       = q_vld && bus.Q_Ready;
    assign push      = (RD_LAT == 2) ? vld_p2 : vld_p1;
    assign push_tag  = (RD_LAT == 2) ? tag_p2 : tag_p1;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (iss_last) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // p0: address issue; the RAM port is shared with the reload path while idle
    assign ram_addr      = (state == IDLE) ? bus.Wr_Addr : base_r + iss_off[ADDR_W-1:0];
    assign tag_p0.offset = iss_off;
    assign tag_p0.last   = iss_last;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic we_c;
        assign we_c = wr_ok && (int'(bus.Wr_Ch) == c);
        bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .RD_LAT (RD_LAT)
        ) u_ram (
            .clk   (Clk),
            .we    (we_c),
            .addr  (ram_addr),
            .wdata (bus.Wr_Data),
            .rdata (ram_q[c])
        );
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            done_r   <= 1'b0;
            wr_err_r <= 1'b0;
        end else begin
            state    <= state_nx;
            vld_p1   <= issue;
            vld_p2   <= vld_p1;
            done_r   <= (state == DRAIN) && (state_nx == IDLE);
            wr_err_r <= bus.Wr_En && !wr_ok;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // p1/p2: tag pipe tracks the RAM read latency; data lands in the FIFO on return
    always_ff @(posedge Clk) begin
        tag_p1 <= tag_p0;
        tag_p2 <= tag_p1;
        if (start_ok) begin
            base_r  <= bus.Base_Addr;
            len_r   <= bus.Length;
            iss_off <= '0;
        end else if (issue) begin
            iss_off <= iss_off + 1'b1;
        end
        if (push) begin
            fifo_data[wr_ptr] <= ram_q;
            fifo_tag[wr_ptr]  <= push_tag;
        end
    end

    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = done_r;
    assign bus.Wr_Err  = wr_err_r;
    assign bus.Q_Valid = q_vld;
    assign bus.Q       = q_vld ? fifo_data[rd_ptr] : '0;
    assign bus.Q_Index = q_vld ? head.offset : '0;
    assign bus.Q_Last  = q_vld && head.last;

endmodule
